// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package mem_responder_pkg;

    localparam int unsigned BUS_W     = 32;
    localparam int unsigned BUS_EXT_W = BUS_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Word-aligned and inside [base, base + depth*4); the span is one bit wider so it cannot wrap.
    function automatic logic addr_ok(input logic [BUS_W-1:0] addr,
                                     input logic [BUS_W-1:0] base,
                                     input int unsigned      depth_words);
        logic [BUS_W-1:0]     off;
        logic [BUS_EXT_W-1:0] span;
        off  = addr - base;
        span = BUS_EXT_W'(depth_words) << 2;
        return (addr[1:0] == 2'b00) && (addr >= base) && ({1'b0, off} < span);
    endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Word storage: synchronous write, combinational read, synchronous clear on reset.
module mem_responder_array
    import mem_responder_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = 256,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [AW-1:0]    widx_i,
    input  logic [BUS_W-1:0] wdata_i,
    input  logic [AW-1:0]    ridx_i,
    output logic [BUS_W-1:0] rdata_c_o
);

    logic [BUS_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[AW'(i)] <= '0;
            end
        end else if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_c_o = mem_q[ridx_i];

endmodule

// File: rtl/mem_responder.sv
// Load/store responder with programmable wait states in front of an internal word array.
// Optional MEM_RESP_STATS_EN adds saturating read/write/error counters.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [15:0] stat_reads,
    output logic [15:0] stat_writes,
    output logic [15:0] stat_errors
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             lat_write_q, lat_write_d;
    logic [BUS_W-1:0] lat_addr_q, lat_addr_d;
    logic [BUS_W-1:0] lat_wdata_q, lat_wdata_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [BUS_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;

    logic             acc_c;
    logic             acc_write_c;
    logic [BUS_W-1:0] acc_addr_c;
    logic [BUS_W-1:0] acc_wdata_c;
    logic             acc_ok_c;
    logic [AW-1:0]    acc_idx_c;
    logic [BUS_W-1:0] rd_data_c;

    mem_responder_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk       (clk),
        .reset     (reset),
        .we_i      (acc_c && acc_ok_c && acc_write_c),
        .widx_i    (acc_idx_c),
        .wdata_i   (acc_wdata_c),
        .ridx_i    (acc_idx_c),
        .rdata_c_o (rd_data_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lat_write_q <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_write_q <= lat_write_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_write_d = lat_write_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        acc_c       = 1'b0;
        acc_write_c = lat_write_q;
        acc_addr_c  = lat_addr_q;
        acc_wdata_c = lat_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    lat_write_d = req_write;
                    lat_addr_d  = req_addr;
                    lat_wdata_d = req_wdata;
                    cnt_d       = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: access straight from the request bus.
                        acc_c       = 1'b1;
                        acc_write_c = req_write;
                        acc_addr_c  = req_addr;
                        acc_wdata_c = req_wdata;
                        state_d     = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    acc_c   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        acc_ok_c  = addr_ok(acc_addr_c, ADDR_BASE, DEPTH_WORDS);
        acc_idx_c = AW'((acc_addr_c - ADDR_BASE) >> 2);
        if (acc_c) begin
            rsp_err_d   = !acc_ok_c;
            rsp_rdata_d = (acc_ok_c && !acc_write_c) ? rd_data_c : '0;
        end

        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

`ifdef MEM_RESP_STATS_EN
    logic [15:0] reads_q, writes_q, errors_q;

    // Saturating per-class counters, bumped on the access edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            reads_q  <= '0;
            writes_q <= '0;
            errors_q <= '0;
        end else if (acc_c) begin
            if (!acc_ok_c) begin
                if (errors_q != 16'hFFFF) errors_q <= errors_q + 16'd1;
            end else if (acc_write_c) begin
                if (writes_q != 16'hFFFF) writes_q <= writes_q + 16'd1;
            end else begin
                if (reads_q != 16'hFFFF) reads_q <= reads_q + 16'd1;
            end
        end
    end

    assign stat_reads  = reads_q;
    assign stat_writes = writes_q;
    assign stat_errors = errors_q;
`endif

endmodule
